// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg: shared types for the reservation-station issue queue.   Rev 1.0
// ---------------------------------------------------------------------------
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

`default_nettype none

package rs_pkg;

  localparam int c_val_w = `REG_VAL_WIDTH;
  localparam int c_tag_w = `PHYSICAL_REG_NUM_WIDTH;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] fu_sel;
    logic       use_imm;
  } control_t;

  typedef struct packed {
    logic               valid;
    control_t           control;
    logic [c_tag_w-1:0] src1_tag;
    logic [c_val_w-1:0] src1_val;
    logic               src1_rdy;
    logic [c_tag_w-1:0] src2_tag;
    logic [c_val_w-1:0] src2_val;
    logic               src2_rdy;
    logic [c_tag_w-1:0] dst_tag;
    logic [c_val_w-1:0] imm;
  } rs_entry_t;

  typedef struct packed {
    logic               valid;
    logic [c_tag_w-1:0] tag;
    logic [c_val_w-1:0] val;
  } cdb_t;

endpackage

`default_nettype wire

// File: rtl/rs_issue_queue_prio_select.sv
// ---------------------------------------------------------------------------
// rs_prio_select: lowest-index-set priority encoder, one-hot grant.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rs_prio_select #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [WIDTH-1:0] o_grant,
  output logic             o_found
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_grant = i_req & (~i_req + WIDTH'(1));
  assign o_found = |i_req;

endmodule

`default_nettype wire

// File: rtl/rs_issue_queue.sv
// ---------------------------------------------------------------------------
// rs_issue_queue: multi-entry reservation station with CDB wakeup.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rs_issue_queue
  import rs_pkg::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int NUM_CDB  = 2,
  parameter int VAL_W    = `REG_VAL_WIDTH,
  parameter int TAG_W    = `PHYSICAL_REG_NUM_WIDTH,
  parameter int CNT_W    = $clog2(RS_DEPTH+1)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  control_t                      disp_control,
  input  logic [TAG_W-1:0]              disp_src1_tag,
  input  logic [TAG_W-1:0]              disp_src2_tag,
  input  logic [VAL_W-1:0]              disp_src1_val,
  input  logic [VAL_W-1:0]              disp_src2_val,
  input  logic                          disp_src1_rdy,
  input  logic                          disp_src2_rdy,
  input  logic [TAG_W-1:0]              disp_dst_tag,
  input  logic [VAL_W-1:0]              disp_imm,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB-1:0][VAL_W-1:0] cdb_val,
  output logic                          iss_valid,
  input  logic                          iss_ready,
  output control_t                      iss_control,
  output logic [VAL_W-1:0]              iss_src1_val,
  output logic [VAL_W-1:0]              iss_src2_val,
  output logic [TAG_W-1:0]              iss_dst_tag,
  output logic [VAL_W-1:0]              iss_imm,
  output logic [CNT_W-1:0]              occupancy
);

  rs_entry_t            r_entries [RS_DEPTH];
  rs_entry_t            w_next    [RS_DEPTH];
  rs_entry_t            w_iss_entry;
  cdb_t                 w_cdb     [NUM_CDB];
  logic [CNT_W-1:0]     r_occ;
  logic [RS_DEPTH-1:0]  w_free_req;
  logic [RS_DEPTH-1:0]  w_free_oh;
  logic [RS_DEPTH-1:0]  w_elig;
  logic [RS_DEPTH-1:0]  w_iss_oh;
  logic                 w_any_free;
  logic                 w_iss_found;
  logic                 w_disp_hs;
  logic                 w_iss_hs;
  logic [VAL_W:0]       w_byp1;
  logic [VAL_W:0]       w_byp2;
  logic [VAL_W:0]       w_wake1;
  logic [VAL_W:0]       w_wake2;

  // Returns {hit, value}; the lowest-numbered matching port wins.
  function automatic logic [VAL_W:0] f_snoop(input logic [TAG_W-1:0] tag,
                                             input cdb_t cdb [NUM_CDB]);
    logic [VAL_W:0] res;
    res = '0;
    for (int p = NUM_CDB-1; p >= 0; p--) begin
      if (cdb[p].valid && (cdb[p].tag == tag)) res = {1'b1, cdb[p].val};
    end
    return res;
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_CDB; p++) begin
      w_cdb[p].valid = cdb_valid[p];
      w_cdb[p].tag   = cdb_tag[p];
      w_cdb[p].val   = cdb_val[p];
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_free_req[i] = !r_entries[i].valid;
      w_elig[i]     = r_entries[i].valid && r_entries[i].src1_rdy && r_entries[i].src2_rdy;
    end
  end

  rs_prio_select #(.WIDTH(RS_DEPTH)) u_free_sel (
    .i_req   (w_free_req),
    .o_grant (w_free_oh),
    .o_found (w_any_free)
  );

  rs_prio_select #(.WIDTH(RS_DEPTH)) u_iss_sel (
    .i_req   (w_elig),
    .o_grant (w_iss_oh),
    .o_found (w_iss_found)
  );

  assign disp_ready = w_any_free;
  assign iss_valid  = w_iss_found;
  assign w_disp_hs  = disp_valid && w_any_free;
  assign w_iss_hs   = w_iss_found && iss_ready;

  // With no grant the mux yields zeros, which keeps iss_* at 0 when idle.
  always_comb begin
    w_iss_entry = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (w_iss_oh[i]) w_iss_entry = r_entries[i];
    end
  end

  assign iss_control  = w_iss_entry.control;
  assign iss_src1_val = w_iss_entry.src1_val;
  assign iss_src2_val = w_iss_entry.src2_val;
  assign iss_dst_tag  = w_iss_entry.dst_tag;
  assign iss_imm      = w_iss_entry.imm;
  assign occupancy    = r_occ;

  assign w_byp1 = f_snoop(disp_src1_tag, w_cdb);
  assign w_byp2 = f_snoop(disp_src2_tag, w_cdb);

  // Free and issuing entries are disjoint, so dispatch never reuses the issuing slot.
  always_comb begin
    w_wake1 = '0;
    w_wake2 = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_next[i] = r_entries[i];
      w_wake1   = f_snoop(r_entries[i].src1_tag, w_cdb);
      w_wake2   = f_snoop(r_entries[i].src2_tag, w_cdb);
      if (r_entries[i].valid && !r_entries[i].src1_rdy && w_wake1[VAL_W]) begin
        w_next[i].src1_rdy = 1'b1;
        w_next[i].src1_val = w_wake1[VAL_W-1:0];
      end
      if (r_entries[i].valid && !r_entries[i].src2_rdy && w_wake2[VAL_W]) begin
        w_next[i].src2_rdy = 1'b1;
        w_next[i].src2_val = w_wake2[VAL_W-1:0];
      end
      if (w_iss_hs && w_iss_oh[i]) w_next[i].valid = 1'b0;
      if (w_disp_hs && w_free_oh[i]) begin
        w_next[i].valid    = 1'b1;
        w_next[i].control  = disp_control;
        w_next[i].src1_tag = disp_src1_tag;
        w_next[i].src2_tag = disp_src2_tag;
        w_next[i].dst_tag  = disp_dst_tag;
        w_next[i].imm      = disp_imm;
        w_next[i].src1_rdy = disp_src1_rdy || w_byp1[VAL_W];
        w_next[i].src1_val = disp_src1_rdy ? disp_src1_val : w_byp1[VAL_W-1:0];
        w_next[i].src2_rdy = disp_src2_rdy || w_byp2[VAL_W];
        w_next[i].src2_val = disp_src2_rdy ? disp_src2_val : w_byp2[VAL_W-1:0];
      end
      if (flush) w_next[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RS_DEPTH; i++) r_entries[i] <= '0;
      r_occ <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) r_entries[i] <= w_next[i];
      if (flush) begin
        r_occ <= '0;
      end else if (w_disp_hs && !w_iss_hs) begin
        r_occ <= r_occ + CNT_W'(1);
      end else if (!w_disp_hs && w_iss_hs) begin
        r_occ <= r_occ - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- Parametrised multi-entry reservation station that accepts one dispatched instruction per cycle from the physical register file stage.
- Captures source operands that are still pending by snooping NUM_CDB common-data-bus ports, tracking each operand by its physical tag.
- Issues one fully-ready instruction per cycle to its functional unit through a valid/ready handshake.
- Generalises the single-slot regfile-to-RS transfer with: depth; per-operand ready tracking; multi-port wakeup, including same-cycle bypass at dispatch; back-pressure; flush.

Parameters:
- RS_DEPTH, default 8, number of entries; must be at least 2.
- NUM_CDB, default 2, number of broadcast/wakeup ports.
- VAL_W, default `REG_VAL_WIDTH, width of operand and immediate values.
- TAG_W, default `PHYSICAL_REG_NUM_WIDTH, width of a physical register tag.
- CNT_W, default $clog2(RS_DEPTH+1), width of the occupancy counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- disp_valid  in  1  a dispatch is offered this cycle.
- disp_ready  out  1  RS can accept a dispatch (at least one free entry).
- disp_control  in  control_t  decoded control word.
- disp_src1_tag, disp_src2_tag  in  TAG_W  source physical tags.
- disp_src1_val, disp_src2_val  in  VAL_W  source values; meaningful only when the matching ready bit is 1.
- disp_src1_rdy, disp_src2_rdy  in  1  source value is already available.
- disp_dst_tag  in  TAG_W  destination physical tag.
- disp_imm  in  VAL_W  immediate.
- cdb_valid  in  NUM_CDB  per-port broadcast valid.
- cdb_tag  in  NUM_CDB x TAG_W  per-port broadcast tag.
- cdb_val  in  NUM_CDB x VAL_W  per-port broadcast value.
- iss_valid  out  1  an issue is offered this cycle.
- iss_ready  in  1  functional unit accepts the issue.
- iss_control, iss_src1_val, iss_src2_val, iss_dst_tag, iss_imm  out  as at dispatch  fields of the issuing entry.
- occupancy  out  CNT_W  number of valid entries.

Behaviour:
- Reset (asynchronous, resetn = 0):
  - all entry valid bits 0 and occupancy 0;
  - iss_valid 0, disp_ready 1;
  - iss_* data outputs 0.
- Each entry holds: valid, control, src1/src2 tag, value and rdy, dst_tag, imm.
- Dispatch:
  - A handshake occurs when disp_valid && disp_ready.
  - The instruction is written into the lowest-index free entry.
  - disp_ready = any entry free, computed from registered state only; an entry freed by an issue in the same cycle does not count.
- Dispatch bypass: a source arriving with rdy = 0 whose tag matches a valid CDB port in the same cycle is stored with rdy = 1 and that port's value.
- Wakeup:
  - Every cycle, each valid entry with srcN_rdy = 0 compares srcN_tag against every valid CDB port.
  - On a match the entry latches the value and sets rdy.
  - If several ports match, the lowest port index wins.
- Issue:
  - An entry is eligible when valid && src1_rdy && src2_rdy, using registered state.
  - An entry woken in cycle t is therefore eligible from t+1 at the earliest.
  - Minimum latency from dispatch (with both sources ready) to iss_valid is 1 cycle.
  - The selected entry is the lowest-index eligible entry.
  - iss_valid and the iss_* outputs are combinational from registered entry state.
  - The entry is cleared on iss_valid && iss_ready.
  - While iss_ready = 0 the selection may change if a lower-index entry becomes eligible; there is no hold requirement on the offered entry.
- Simultaneous dispatch and issue: both take effect; occupancy is unchanged. The dispatch never reuses the issuing entry in that same cycle.
- Occupancy: +1 on a dispatch handshake, -1 on an issue handshake, unchanged when both occur. It never exceeds RS_DEPTH and never underflows.
- Flush: on the next edge all valid bits and occupancy are set to 0. Flush has priority over dispatch, issue and wakeup in that cycle. The iss_valid presented during the flush cycle remains legal for the FU to take.
- A CDB tag matching no pending entry has no effect.
- Stored values of entries that are not valid are don't-care.

Decomposition:
- Shared package rs_pkg:
  - rs_entry_t struct (fields as listed in Behaviour);
  - cdb_t struct {valid, tag, val};
  - reuses the existing control_t and the `REG_VAL_WIDTH / `PHYSICAL_REG_NUM_WIDTH macros.
- Sub-module rs_prio_select: parametrised lowest-index-set priority encoder (one-hot grant plus found flag). It is instantiated twice, once for free-entry allocation and once for issue selection.

Test Plan (RS_DEPTH = 4, NUM_CDB = 2):
- Reset then dispatch {src1_rdy = 1, val = 5; src2_rdy = 1, val = 7; dst = 12}, iss_ready = 1 -> iss_valid = 1 on the next cycle with src1 = 5, src2 = 7, dst_tag = 12; occupancy returns 1 -> 0.
- Dispatch with src2 tag 9 not ready; two cycles later CDB port 1 broadcasts {tag 9, val 0xAB} -> iss_valid asserts exactly one cycle after the broadcast with src2 = 0xAB.
- Dispatch with src1 tag 3 not ready while CDB port 0 broadcasts {tag 3, val 0x11} in the same cycle -> entry stored ready; issue next cycle with src1 = 0x11.
- Hold iss_ready = 0 and dispatch 4 instructions -> disp_ready = 0 and occupancy = 4; a fifth disp_valid is not accepted. Then pulse iss_ready for one cycle while disp_valid = 1 -> entry 0 issues, no dispatch accepted that cycle, disp_ready = 1 the following cycle.
- Entries 0 and 2 pending, entry 1 ready -> entry 1 issues first. CDB wakes entries 0 and 2 together -> entry 0 issues before entry 2.
- Assert flush with occupancy = 3 while disp_valid = 1 -> occupancy = 0 and iss_valid = 0 next cycle, dispatch discarded. Assert resetn = 0 mid-operation -> all outputs reach reset values immediately, without waiting for a clock edge.
